mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the CPU's second block-RAM port between up to NUM_REQ on-chip requesters, such as a VGA glyph fetcher, a program loader and a debug/UART bridge. That port carries data, address, write-enable and read-data.
- Performs round-robin arbitration with an optional fixed-priority requester 0.
- Allows one outstanding transaction at a time.
- Sequences the address/write cycle and the read-latency wait, then returns read data to the owner with a valid pulse.

Parameters:
- WIDTH, 16, data width of the memory port.
- ADDR_WIDTH, 16, address width of the memory port.
- NUM_REQ, 3, number of requesters (2..8).
- READ_LATENCY, 1, cycles from address cycle to valid mem_rdata (1..4).
- PRIO0, 0, when 1 requester 0 always wins if requesting; the others are round-robin.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held until gnt.
- req_we  in  NUM_REQ  per-requester write flag (1 = write, 0 = read).
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i in slice i.
- req_wdata  in  NUM_REQ*WIDTH  packed write data.
- gnt  out  NUM_REQ  one-hot, one-cycle pulse in the access cycle.
- rvalid  out  NUM_REQ  one-hot, one-cycle pulse when rdata is valid for that requester.
- rdata  out  WIDTH  registered read data, broadcast to all requesters.
- mem_addr  out  ADDR_WIDTH  to memory port address.
- mem_wdata  out  WIDTH  to memory port write data.
- mem_we  out  1  to memory port write enable.
- mem_rdata  in  WIDTH  from memory port read data.
- busy  out  1  high whenever state != IDLE.
- owner  out  3  index of the current or last granted requester.

Behaviour:
- Reset (async, high) values: state=IDLE, rr pointer=0, gnt=0, rvalid=0, rdata=0, mem_addr=0, mem_wdata=0, mem_we=0, busy=0, owner=0.
- Reset asserted mid-transaction aborts it immediately: mem_we drops asynchronously and no rvalid is ever issued for the aborted read.
- FSM states:
  - IDLE: if any req bit is set, pick a winner, latch its addr/wdata/we into the mem_* registers and set owner. Then go to ACCESS. Otherwise stay in IDLE with mem_we=0.
  - ACCESS (exactly 1 cycle): mem_* registers drive the port and gnt[owner]=1. A write goes to IDLE. A read goes to WAIT with counter=READ_LATENCY-1.
  - WAIT: hold mem_addr with mem_we=0. When counter=0, capture mem_rdata into rdata and go to IDLE, asserting rvalid[owner] in that IDLE cycle. Otherwise decrement the counter.
- mem_we is high only during ACCESS of a write, for exactly 1 cycle per write.
- Winner selection:
  - PRIO0=1 and req[0] set: winner is 0.
  - Otherwise: first set bit scanning from ptr upward, wrapping modulo NUM_REQ.
  - After each grant, ptr = winner+1, wrapping NUM_REQ-1 to 0. With PRIO0=1, a requester-0 grant leaves ptr unchanged.
- Latency, with request first seen in IDLE at cycle 0:
  - Write: gnt at cycle 1; the next arbitration can happen at cycle 2.
  - Read: gnt at cycle 1; rvalid/rdata at cycle 2+READ_LATENCY, which is also an IDLE cycle that may arbitrate.
- Requester protocol:
  - Keep req, req_we, req_addr and req_wdata stable from assertion until the gnt cycle.
  - Deassert req in the cycle after gnt, otherwise it is treated as a new request.
  - req dropped before being sampled in IDLE: no effect.
  - req dropped after sampling: the latched transaction still completes.
- Simultaneous events:
  - rvalid for one requester and arbitration for the next happen in the same IDLE cycle. Both are legal and independent.
  - All requesters asserting continuously are served in strict rotation. Worst-case wait is (NUM_REQ-1) transactions, or unbounded for others under PRIO0=1 saturation, which is documented as user responsibility.
- owner holds its value through IDLE until the next grant.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, ACCESS, WAIT}, 2-bit encoding;
  - default WIDTH and ADDR_WIDTH constants;
  - max NUM_REQ=8.
- Sub-module rr_picker (combinational): inputs req vector, ptr and PRIO0; outputs winner index and a found flag. It can be verified exhaustively on its own.
- The remainder (FSM, counter, registers, packing) sits in mem_port_arbiter.

Test Plan:
1. Single read: req[1]=1, addr 0x0040, memory holds 0xBEEF, READ_LATENCY=1 -> gnt[1] at cycle 1, mem_addr=0x0040, mem_we=0; rvalid[1]=1 with rdata=0xBEEF at cycle 3; busy high cycles 1-2.
2. Single write: req[2]=1, we=1, addr 0x1234, data 0xA5A5 -> mem_we=1 only at cycle 1 with mem_addr=0x1234, mem_wdata=0xA5A5; gnt[2] at cycle 1; no rvalid; busy low at cycle 2.
3. Round-robin, PRIO0=0, all three requesting reads held until each gnt, ptr=0 -> grants in order 0,1,2 at cycles 1,4,7; each rvalid one-hot matches owner; ptr returns to 0.
4. PRIO0=1, req[0] and req[1] both continuously requesting writes -> req[0] granted every transaction while set; after req[0] drops, req[1] is granted at the next arbitration.
5. READ_LATENCY=3 read from addr 0x00FF returning 0x0102 -> gnt at cycle 1, mem_we=0 in cycles 1-4, rvalid at cycle 5 with rdata=0x0102.
6. Reset asserted during WAIT of a read -> all outputs return to reset values in the same cycle with no clock edge needed; no rvalid after release; the next request is served from IDLE with ptr=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the block-RAM port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } arb_state_e;

    localparam int DEFAULT_WIDTH      = 16;
    localparam int DEFAULT_ADDR_WIDTH = 16;
    localparam int MAX_NUM_REQ        = 8;
    localparam int OWNER_W            = 3;
    localparam int CNT_W              = 2;

    // Turn a requester index into a one-hot vector of the maximum width.
    function automatic logic [MAX_NUM_REQ-1:0] idx_to_onehot(input logic [OWNER_W-1:0] idx);
        return MAX_NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin winner selection with optional priority for requester 0.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OWNER_W-1:0] ptr,
    input  logic               prio0,
    output logic [OWNER_W-1:0] winner,
    output logic               found
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [OWNER_W-1:0]   off;
    logic [OWNER_W:0]     sum;
    logic                 found_any;

    assign dbl = {req, req};

    // Rotate the request vector so bit 0 is the pointer position, take the lowest set bit, then undo the rotation.
    always_comb begin
        rot       = NUM_REQ'(dbl >> ptr);
        off       = '0;
        found_any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off       = OWNER_W'(k);
                found_any = 1'b1;
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (OWNER_W + 1)'(NUM_REQ)) begin
            sum = sum - (OWNER_W + 1)'(NUM_REQ);
        end
        if (prio0 && req[0]) begin
            winner = '0;
            found  = 1'b1;
        end else begin
            winner = found_any ? sum[OWNER_W-1:0] : '0;
            found  = found_any;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one block-RAM port between several requesters, one transaction at a time.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int NUM_REQ      = 3,
    parameter int READ_LATENCY = 1,
    parameter int PRIO0        = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [WIDTH-1:0]              rdata,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [WIDTH-1:0]              mem_wdata,
    output logic                          mem_we,
    input  logic [WIDTH-1:0]              mem_rdata,
    output logic                          busy,
    output logic [OWNER_W-1:0]            owner
);

    arb_state_e             state_q, state_d;
    logic [OWNER_W-1:0]     ptr_q, ptr_d;
    logic [OWNER_W-1:0]     owner_q, owner_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic [NUM_REQ-1:0]     rvalid_q, rvalid_d;
    logic [WIDTH-1:0]       rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]       mem_wdata_q, mem_wdata_d;
    logic                   mem_we_q, mem_we_d;

    logic [OWNER_W-1:0]     winner;
    logic                   found;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [WIDTH-1:0]       sel_wdata;
    logic                   sel_we;

    rr_picker #(
        .NUM_REQ(NUM_REQ)
    ) u_picker (
        .req   (req),
        .ptr   (ptr_q),
        .prio0 (PRIO0 != 0),
        .winner(winner),
        .found (found)
    );

    // Pull the winning requester's transaction out of the packed input buses.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == OWNER_W'(i)) begin
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*WIDTH +: WIDTH];
                sel_we    = req_we[i];
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, drive the port for one ACCESS cycle, then count out the read latency.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        rvalid_d    = '0;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    mem_we_d    = sel_we;
                    owner_d     = winner;
                    gnt_d       = NUM_REQ'(idx_to_onehot(winner));
                    state_d     = ACCESS;
                    if (!((PRIO0 != 0) && (winner == '0))) begin
                        if (winner == OWNER_W'(NUM_REQ - 1)) begin
                            ptr_d = '0;
                        end else begin
                            ptr_d = winner + OWNER_W'(1);
                        end
                    end
                end
            end
            ACCESS: begin
                if (mem_we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(READ_LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d  = mem_rdata;
                    rvalid_d = NUM_REQ'(idx_to_onehot(owner_q));
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign gnt       = gnt_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign owner     = owner_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three configurations share one stimulus, plus the picker on its own.
module tb_mem_port_arbiter;

    typedef struct {
        logic [2:0] req;
        logic [2:0] ptr;
        logic       prio0;
        logic [2:0] winner;
        logic       found;
    } pickVec_t;

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  gnt;
        logic [2:0]  rvalid;
        logic        busy;
        logic [2:0]  owner;
        logic [15:0] rdata;
    } rrVec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  req = '0;
    logic [2:0]  reqWe = '0;
    logic [47:0] reqAddr = '0;
    logic [47:0] reqWdata = '0;

    logic [2:0]  gntA, rvalidA, ownerA, gntB, rvalidB, ownerB, gntC, rvalidC, ownerC;
    logic [15:0] rdataA, memAddrA, memWdataA, rdataB, memAddrB, memWdataB, rdataC, memAddrC, memWdataC;
    logic        memWeA, busyA, memWeB, busyB, memWeC, busyC;
    logic [15:0] memRdataA = '0, memRdataB = '0, memRdataC = '0, pipeC1 = '0, pipeC2 = '0;

    logic [2:0]  pickReq = '0, pickPtr = '0, pickWinner;
    logic        pickPrio0 = 1'b0, pickFound;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NUM_REQ(3), .READ_LATENCY(1), .PRIO0(0)) dutA (
        .clk(clk), .reset(reset), .req(req), .req_we(reqWe), .req_addr(reqAddr), .req_wdata(reqWdata),
        .gnt(gntA), .rvalid(rvalidA), .rdata(rdataA), .mem_addr(memAddrA), .mem_wdata(memWdataA),
        .mem_we(memWeA), .mem_rdata(memRdataA), .busy(busyA), .owner(ownerA));

    mem_port_arbiter #(.NUM_REQ(3), .READ_LATENCY(1), .PRIO0(1)) dutB (
        .clk(clk), .reset(reset), .req(req), .req_we(reqWe), .req_addr(reqAddr), .req_wdata(reqWdata),
        .gnt(gntB), .rvalid(rvalidB), .rdata(rdataB), .mem_addr(memAddrB), .mem_wdata(memWdataB),
        .mem_we(memWeB), .mem_rdata(memRdataB), .busy(busyB), .owner(ownerB));

    mem_port_arbiter #(.NUM_REQ(3), .READ_LATENCY(3), .PRIO0(0)) dutC (
        .clk(clk), .reset(reset), .req(req), .req_we(reqWe), .req_addr(reqAddr), .req_wdata(reqWdata),
        .gnt(gntC), .rvalid(rvalidC), .rdata(rdataC), .mem_addr(memAddrC), .mem_wdata(memWdataC),
        .mem_we(memWeC), .mem_rdata(memRdataC), .busy(busyC), .owner(ownerC));

    rr_picker #(.NUM_REQ(3)) picker (
        .req(pickReq), .ptr(pickPtr), .prio0(pickPrio0), .winner(pickWinner), .found(pickFound));

    // Read-only memory contents: two known words, everything else derived from the address.
    function automatic logic [15:0] memVal(input logic [15:0] a);
        if (a == 16'h0040) return 16'hBEEF;
        if (a == 16'h00FF) return 16'h0102;
        return a ^ 16'h5A5A;
    endfunction

    // Synchronous RAM models: one register stage for latency 1, three for latency 3.
    always @(posedge clk) begin
        memRdataA <= memVal(memAddrA);
        memRdataB <= memVal(memAddrB);
        pipeC1    <= memVal(memAddrC);
        pipeC2    <= pipeC1;
        memRdataC <= pipeC2;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] r, input logic [2:0] w);
        req   = r;
        reqWe = w;
    endtask

    task automatic setPort(input int i, input logic [15:0] a, input logic [15:0] d);
        reqAddr[i*16 +: 16]  = a;
        reqWdata[i*16 +: 16] = d;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(3'b000, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    pickVec_t pickTab[13];
    rrVec_t   rrTab[10];
    logic     seenRv;

    initial begin
        pickTab[0]  = '{3'b000, 3'd0, 1'b0, 3'd0, 1'b0};
        pickTab[1]  = '{3'b001, 3'd0, 1'b0, 3'd0, 1'b1};
        pickTab[2]  = '{3'b010, 3'd0, 1'b0, 3'd1, 1'b1};
        pickTab[3]  = '{3'b101, 3'd1, 1'b0, 3'd2, 1'b1};
        pickTab[4]  = '{3'b101, 3'd0, 1'b0, 3'd0, 1'b1};
        pickTab[5]  = '{3'b011, 3'd2, 1'b0, 3'd0, 1'b1};
        pickTab[6]  = '{3'b110, 3'd2, 1'b0, 3'd2, 1'b1};
        pickTab[7]  = '{3'b111, 3'd1, 1'b0, 3'd1, 1'b1};
        pickTab[8]  = '{3'b111, 3'd1, 1'b1, 3'd0, 1'b1};
        pickTab[9]  = '{3'b110, 3'd0, 1'b1, 3'd1, 1'b1};
        pickTab[10] = '{3'b100, 3'd1, 1'b1, 3'd2, 1'b1};
        pickTab[11] = '{3'b010, 3'd2, 1'b0, 3'd1, 1'b1};
        pickTab[12] = '{3'b000, 3'd1, 1'b1, 3'd0, 1'b0};

        // Three reads in rotation on the latency-1 round-robin instance, one row per cycle.
        rrTab[0] = '{3'b111, 3'b000, 3'b000, 1'b0, 3'd0, 16'h0000};
        rrTab[1] = '{3'b110, 3'b001, 3'b000, 1'b1, 3'd0, 16'h0000};
        rrTab[2] = '{3'b110, 3'b000, 3'b000, 1'b1, 3'd0, 16'h0000};
        rrTab[3] = '{3'b110, 3'b000, 3'b001, 1'b0, 3'd0, 16'h5A4A};
        rrTab[4] = '{3'b100, 3'b010, 3'b000, 1'b1, 3'd1, 16'h0000};
        rrTab[5] = '{3'b100, 3'b000, 3'b000, 1'b1, 3'd1, 16'h0000};
        rrTab[6] = '{3'b100, 3'b000, 3'b010, 1'b0, 3'd1, 16'h5A7A};
        rrTab[7] = '{3'b000, 3'b100, 3'b000, 1'b1, 3'd2, 16'h0000};
        rrTab[8] = '{3'b000, 3'b000, 3'b000, 1'b1, 3'd2, 16'h0000};
        rrTab[9] = '{3'b000, 3'b000, 3'b100, 1'b0, 3'd2, 16'h5A6A};

        // Reset values appear without any clock edge.
        #1 reset = 1'b1;
        #1;
        checkOutput("rst_gntA", 32'(gntA), 0);
        checkOutput("rst_rvalidA", 32'(rvalidA), 0);
        checkOutput("rst_busyA", 32'(busyA), 0);
        checkOutput("rst_memWeA", 32'(memWeA), 0);
        checkOutput("rst_memAddrA", 32'(memAddrA), 0);
        checkOutput("rst_memWdataA", 32'(memWdataA), 0);
        checkOutput("rst_ownerA", 32'(ownerA), 0);
        checkOutput("rst_rdataA", 32'(rdataA), 0);
        checkOutput("rst_rdataB", 32'(rdataB), 0);
        checkOutput("rst_rdataC", 32'(rdataC), 0);

        for (int i = 0; i < 13; i++) begin
            pickReq   = pickTab[i].req;
            pickPtr   = pickTab[i].ptr;
            pickPrio0 = pickTab[i].prio0;
            #1;
            checkOutput($sformatf("pick%0d_winner", i), 32'(pickWinner), 32'(pickTab[i].winner));
            checkOutput($sformatf("pick%0d_found", i), 32'(pickFound), 32'(pickTab[i].found));
        end

        // Single read from requester 1.
        doReset();
        setPort(1, 16'h0040, 16'h0000);
        applyStimulus(3'b010, 3'b000);
        nextCycle();
        checkOutput("rd_gnt", 32'(gntA), 32'b010);
        checkOutput("rd_memAddr", 32'(memAddrA), 32'h0040);
        checkOutput("rd_memWe", 32'(memWeA), 0);
        checkOutput("rd_busy1", 32'(busyA), 1);
        applyStimulus(3'b000, 3'b000);
        nextCycle();
        checkOutput("rd_busy2", 32'(busyA), 1);
        checkOutput("rd_rvalid2", 32'(rvalidA), 0);
        nextCycle();
        checkOutput("rd_rvalid3", 32'(rvalidA), 32'b010);
        checkOutput("rd_rdata3", 32'(rdataA), 32'hBEEF);
        checkOutput("rd_busy3", 32'(busyA), 0);

        // Single write from requester 2.
        doReset();
        setPort(2, 16'h1234, 16'hA5A5);
        applyStimulus(3'b100, 3'b100);
        nextCycle();
        checkOutput("wr_memWe1", 32'(memWeA), 1);
        checkOutput("wr_memAddr", 32'(memAddrA), 32'h1234);
        checkOutput("wr_memWdata", 32'(memWdataA), 32'hA5A5);
        checkOutput("wr_gnt", 32'(gntA), 32'b100);
        applyStimulus(3'b000, 3'b000);
        nextCycle();
        checkOutput("wr_memWe2", 32'(memWeA), 0);
        checkOutput("wr_busy2", 32'(busyA), 0);
        checkOutput("wr_gnt2", 32'(gntA), 0);
        nextCycle();
        checkOutput("wr_rvalid3", 32'(rvalidA), 0);

        // Round-robin rotation driven from the table.
        doReset();
        setPort(0, 16'h0010, 16'h0000);
        setPort(1, 16'h0020, 16'h0000);
        setPort(2, 16'h0030, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("rr%0d_gnt", i), 32'(gntA), 32'(rrTab[i].gnt));
            checkOutput($sformatf("rr%0d_rvalid", i), 32'(rvalidA), 32'(rrTab[i].rvalid));
            checkOutput($sformatf("rr%0d_busy", i), 32'(busyA), 32'(rrTab[i].busy));
            checkOutput($sformatf("rr%0d_owner", i), 32'(ownerA), 32'(rrTab[i].owner));
            if (rrTab[i].rvalid != 3'b000) begin
                checkOutput($sformatf("rr%0d_rdata", i), 32'(rdataA), 32'(rrTab[i].rdata));
            end
            applyStimulus(rrTab[i].req, 3'b000);
            nextCycle();
        end
        applyStimulus(3'b101, 3'b000);
        nextCycle();
        checkOutput("rr_ptrWrap_gnt", 32'(gntA), 32'b001);
        applyStimulus(3'b000, 3'b000);
        repeat (4) nextCycle();

        // Fixed priority for requester 0 under continuous writes.
        doReset();
        setPort(0, 16'h0100, 16'h1111);
        setPort(1, 16'h0200, 16'h2222);
        applyStimulus(3'b011, 3'b011);
        nextCycle();
        checkOutput("p0_gnt1", 32'(gntB), 32'b001);
        checkOutput("p0_wdata1", 32'(memWdataB), 32'h1111);
        checkOutput("p0_we1", 32'(memWeB), 1);
        nextCycle();
        nextCycle();
        checkOutput("p0_gnt3", 32'(gntB), 32'b001);
        checkOutput("p0_rrContrast3", 32'(gntA), 32'b010);
        nextCycle();
        nextCycle();
        checkOutput("p0_gnt5", 32'(gntB), 32'b001);
        applyStimulus(3'b010, 3'b010);
        nextCycle();
        nextCycle();
        checkOutput("p0_gnt7", 32'(gntB), 32'b010);
        checkOutput("p0_owner7", 32'(ownerB), 1);
        checkOutput("p0_rvalid7", 32'(rvalidB), 0);
        checkOutput("p0_busy7", 32'(busyB), 1);
        applyStimulus(3'b000, 3'b000);
        repeat (3) nextCycle();

        // Read with latency 3.
        doReset();
        setPort(0, 16'h00FF, 16'h0000);
        applyStimulus(3'b001, 3'b000);
        nextCycle();
        checkOutput("l3_gnt", 32'(gntC), 32'b001);
        checkOutput("l3_memAddr", 32'(memAddrC), 32'h00FF);
        checkOutput("l3_memWe1", 32'(memWeC), 0);
        applyStimulus(3'b000, 3'b000);
        for (int c = 2; c <= 4; c++) begin
            nextCycle();
            checkOutput($sformatf("l3_memWe%0d", c), 32'(memWeC), 0);
            checkOutput($sformatf("l3_rvalid%0d", c), 32'(rvalidC), 0);
            checkOutput($sformatf("l3_busy%0d", c), 32'(busyC), 1);
        end
        nextCycle();
        checkOutput("l3_rvalid5", 32'(rvalidC), 32'b001);
        checkOutput("l3_rdata5", 32'(rdataC), 32'h0102);
        checkOutput("l3_busy5", 32'(busyC), 0);

        // Reset in the middle of a read wait.
        doReset();
        setPort(1, 16'h0040, 16'h0000);
        applyStimulus(3'b010, 3'b000);
        nextCycle();
        checkOutput("ab_gnt", 32'(gntC), 32'b010);
        applyStimulus(3'b000, 3'b000);
        nextCycle();
        checkOutput("ab_busyBefore", 32'(busyC), 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("ab_busy", 32'(busyC), 0);
        checkOutput("ab_memAddr", 32'(memAddrC), 0);
        checkOutput("ab_owner", 32'(ownerC), 0);
        checkOutput("ab_rvalid", 32'(rvalidC), 0);
        checkOutput("ab_gntNow", 32'(gntC), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        seenRv = 1'b0;
        for (int c = 0; c < 6; c++) begin
            nextCycle();
            seenRv = seenRv | (|rvalidC);
        end
        checkOutput("ab_noRvalid", 32'(seenRv), 0);
        setPort(0, 16'h0030, 16'h0000);
        setPort(2, 16'h0040, 16'h0000);
        applyStimulus(3'b101, 3'b000);
        nextCycle();
        checkOutput("ab_ptrReset_gnt", 32'(gntC), 32'b001);
        applyStimulus(3'b000, 3'b000);
        repeat (6) nextCycle();

        // Reset during the access cycle of a write drops the write enable at once.
        doReset();
        setPort(2, 16'h1234, 16'hA5A5);
        applyStimulus(3'b100, 3'b100);
        nextCycle();
        checkOutput("abw_weBefore", 32'(memWeA), 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("abw_we", 32'(memWeA), 0);
        checkOutput("abw_gnt", 32'(gntA), 0);
        checkOutput("abw_wdata", 32'(memWdataA), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
